// File: rtl/f_measure_seq_if.sv
// Control, datapath and result signals between the measurement sequencer and its neighbours.
// The sequencer takes the slave side; the datapath/consumer model takes the master side.
interface f_measure_seq_if;
    logic        start;
    logic        cont;
    logic        cnt_busy;
    logic [30:0] m_cnt;
    logic [26:0] n_cnt;
    logic        cnt_clr;
    logic        gate_req;
    logic        div_sel;
    logic        busy;
    logic        result_valid;
    logic        result_ack;
    logic [30:0] m_out;
    logic [26:0] n_out;
    logic        no_signal;
    logic        overflow;

    modport master (
        output start, cont, cnt_busy, m_cnt, n_cnt, result_ack,
        input  cnt_clr, gate_req, div_sel, busy, result_valid, m_out, n_out, no_signal, overflow
    );

    modport slave (
        input  start, cont, cnt_busy, m_cnt, n_cnt, result_ack,
        output cnt_clr, gate_req, div_sel, busy, result_valid, m_out, n_out, no_signal, overflow
    );
endinterface

// File: rtl/f_measure_seq.sv
// Frequency-meter measurement sequencer: gate control, dead-input timeout, auto-ranging
// between direct and /16 paths, and a valid/ack result register.
module f_measure_seq #(
    parameter int unsigned GATE_CYCLES    = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
    parameter int unsigned M_HIGH         = 10_000_000,
    parameter int unsigned M_LOW          = 500_000
) (
    input  logic           clk,
    input  logic           rst,
    f_measure_seq_if.slave bus
);

    localparam int unsigned MAX_CYC = (GATE_CYCLES > TIMEOUT_CYCLES) ? GATE_CYCLES
                                                                     : TIMEOUT_CYCLES;
    localparam int unsigned TW = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    localparam logic [TW-1:0] GATE_LAST = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [30:0]   M_HIGH_W  = 31'(M_HIGH);
    localparam logic [30:0]   M_LOW_W   = 31'(M_LOW);

    typedef enum logic [2:0] {StIdle, StClear, StOpen, StClose, StLatch, StDone} state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_busy_s;
    logic [TW-1:0]   r_gate_tmr;
    logic [TW-1:0]   r_to_tmr;
    logic            r_seen;
    logic            r_timeout;
    logic            r_cnt_clr;
    logic            r_gate_req;
    logic            r_div_sel;
    logic            r_busy;
    logic            r_valid;
    logic [30:0]     r_m_out;
    logic [26:0]     r_n_out;
    logic            r_no_signal;
    logic            r_overflow;

    logic            w_seen;
    logic            w_m_sat;
    logic [30:0]     w_m_scaled;

    assign w_seen     = r_seen | r_busy_s;
    assign w_m_sat    = |bus.m_cnt[30:27];
    assign w_m_scaled = {bus.m_cnt[26:0], 4'b0000};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_sync1     <= 1'b0;
            r_busy_s    <= 1'b0;
            r_gate_tmr  <= '0;
            r_to_tmr    <= '0;
            r_seen      <= 1'b0;
            r_timeout   <= 1'b0;
            r_cnt_clr   <= 1'b0;
            r_gate_req  <= 1'b0;
            r_div_sel   <= 1'b0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_m_out     <= '0;
            r_n_out     <= '0;
            r_no_signal <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_sync1   <= bus.cnt_busy;
            r_busy_s  <= r_sync1;
            r_cnt_clr <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (bus.start || bus.cont) begin
                        r_state   <= StClear;
                        r_cnt_clr <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                StClear: begin
                    r_gate_tmr <= '0;
                    r_to_tmr   <= '0;
                    r_seen     <= 1'b0;
                    r_timeout  <= 1'b0;
                    r_gate_req <= 1'b1;
                    r_state    <= StOpen;
                end
                StOpen: begin
                    // Gate timer parks at its last value so a late busy_s still hits the == test.
                    if (r_gate_tmr != GATE_LAST) r_gate_tmr <= r_gate_tmr + TW'(1);
                    if (!w_seen) r_to_tmr <= r_to_tmr + TW'(1);
                    r_seen <= w_seen;
                    if (!w_seen && r_to_tmr == TO_LAST) begin
                        r_timeout  <= 1'b1;
                        r_gate_req <= 1'b0;
                        r_state    <= StLatch;
                    end else if (w_seen && r_gate_tmr == GATE_LAST) begin
                        r_gate_req <= 1'b0;
                        r_to_tmr   <= '0;
                        r_state    <= StClose;
                    end
                end
                StClose: begin
                    if (!r_busy_s) begin
                        r_state <= StLatch;
                    end else if (r_to_tmr == TO_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= StLatch;
                    end else begin
                        r_to_tmr <= r_to_tmr + TW'(1);
                    end
                end
                StLatch: begin
                    r_valid <= 1'b1;
                    r_state <= StDone;
                    if (r_timeout) begin
                        r_m_out     <= '0;
                        r_n_out     <= '0;
                        r_no_signal <= 1'b1;
                        r_overflow  <= 1'b0;
                        r_div_sel   <= 1'b0;
                    end else begin
                        r_n_out     <= bus.n_cnt;
                        r_no_signal <= 1'b0;
                        // Scaling follows the range this result was taken in; range moves after.
                        if (!r_div_sel) begin
                            r_m_out    <= bus.m_cnt;
                            r_overflow <= 1'b0;
                            if (bus.m_cnt >= M_HIGH_W) r_div_sel <= 1'b1;
                        end else begin
                            r_m_out    <= w_m_sat ? 31'h7FFF_FFFF : w_m_scaled;
                            r_overflow <= w_m_sat;
                            if (bus.m_cnt < M_LOW_W) r_div_sel <= 1'b0;
                        end
                    end
                end
                StDone: begin
                    if (bus.result_ack) begin
                        r_valid <= 1'b0;
                        if (bus.cont || bus.start) begin
                            r_state   <= StClear;
                            r_cnt_clr <= 1'b1;
                        end else begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.cnt_clr      = r_cnt_clr;
    assign bus.gate_req     = r_gate_req;
    assign bus.div_sel      = r_div_sel;
    assign bus.busy         = r_busy;
    assign bus.result_valid = r_valid;
    assign bus.m_out        = r_m_out;
    assign bus.n_out        = r_n_out;
    assign bus.no_signal    = r_no_signal;
    assign bus.overflow     = r_overflow;

endmodule

// File: tb/tb_f_measure_seq.sv
// Self-checking bench for f_measure_seq: vector table, randomized runs against a range model,
// and directed sequences for timeout, continuous mode, start+ack and mid-measurement reset.
module tb_f_measure_seq;
    localparam int unsigned GATE = 100;
    localparam int unsigned TMO  = 300;
    localparam int unsigned MH   = 50;
    localparam int unsigned ML   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    f_measure_seq_if bus ();

    f_measure_seq #(
        .GATE_CYCLES   (GATE),
        .TIMEOUT_CYCLES(TMO),
        .M_HIGH        (MH),
        .M_LOW         (ML)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        logic [30:0] m;
        logic [26:0] n;
        logic [30:0] exp_m;
        logic        exp_ovf;
        logic        exp_div;
    } vec_t;

    vec_t vecs [11];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   alive    = 1'b1;
    int   busy_dly = 5;
    bit   model_div = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Datapath model: the synchronised gate follows gate_req after a delay.
    initial begin
        bus.cnt_busy = 1'b0;
        forever begin
            @(posedge bus.gate_req);
            if (alive) begin
                repeat (busy_dly) @(negedge clk);
                bus.cnt_busy = 1'b1;
                if (bus.gate_req) @(negedge bus.gate_req);
                repeat (3) @(negedge clk);
                bus.cnt_busy = 1'b0;
            end
        end
    end

    function automatic void ref_result(input logic [30:0] m, input bit rng,
                                       output logic [30:0] mo, output bit ovf, output bit nrng);
        longint unsigned scaled;
        scaled = rng ? longint'(m) * 16 : longint'(m);
        ovf    = scaled > 64'h7FFF_FFFF;
        mo     = ovf ? 31'h7FFF_FFFF : scaled[30:0];
        nrng   = rng;
        if (!rng && m >= MH) nrng = 1'b1;
        if (rng && m < ML) nrng = 1'b0;
    endfunction

    task automatic wait_result(input int limit, output int gate_len, output int clr_len,
                               output bit got);
        gate_len = 0;
        clr_len  = 0;
        got      = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clk);
            if (bus.cnt_clr) clr_len++;
            if (bus.gate_req) gate_len++;
            if (bus.result_valid) got = 1'b1;
        end
    endtask

    task automatic meas(input string tag, input logic [30:0] m, input logic [26:0] n,
                        output int gl);
        int cl;
        bit got;
        bus.m_cnt = m;
        bus.n_cnt = n;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_clr_latency"}, bus.cnt_clr, 1);
        wait_result(2000, gl, cl, got);
        check({tag, "_valid"}, got, 1);
        check({tag, "_clr_width"}, cl, 0);
    endtask

    task automatic check_res(input string tag, input logic [30:0] m, input logic [26:0] n,
                             input bit ns, input bit ovf, input bit dv);
        check({tag, "_m_out"}, bus.m_out, m);
        check({tag, "_n_out"}, bus.n_out, n);
        check({tag, "_no_signal"}, bus.no_signal, ns);
        check({tag, "_overflow"}, bus.overflow, ovf);
        check({tag, "_div_sel"}, bus.div_sel, dv);
    endtask

    task automatic do_ack(input string tag);
        @(negedge clk);
        bus.result_ack = 1'b1;
        @(negedge clk);
        bus.result_ack = 1'b0;
        check({tag, "_valid_drop"}, bus.result_valid, 0);
    endtask

    task automatic model_meas(input string tag, input logic [30:0] m, input logic [26:0] n);
        logic [30:0] mo;
        bit ovf, nrng;
        int gl;
        ref_result(m, model_div, mo, ovf, nrng);
        meas(tag, m, n, gl);
        check({tag, "_gate_len"}, gl, GATE);
        check_res(tag, mo, n, 1'b0, ovf, nrng);
        model_div = nrng;
        do_ack(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gl, cl, vcnt;
        bit got;
        logic [30:0] m, mo;
        bit ovf, nrng;

        vecs[0]  = '{m: 31'd20,          n: 27'd100, exp_m: 31'd20,          exp_ovf: 0, exp_div: 0};
        vecs[1]  = '{m: 31'd60,          n: 27'd77,  exp_m: 31'd60,          exp_ovf: 0, exp_div: 1};
        vecs[2]  = '{m: 31'd10,          n: 27'd55,  exp_m: 31'd160,         exp_ovf: 0, exp_div: 1};
        vecs[3]  = '{m: 31'd3,           n: 27'd9,   exp_m: 31'd48,          exp_ovf: 0, exp_div: 0};
        vecs[4]  = '{m: 31'd60,          n: 27'd1,   exp_m: 31'd60,          exp_ovf: 0, exp_div: 1};
        vecs[5]  = '{m: 31'h0800_0000,   n: 27'd5,   exp_m: 31'h7FFF_FFFF,   exp_ovf: 1, exp_div: 1};
        vecs[6]  = '{m: 31'h07FF_FFFF,   n: 27'd6,   exp_m: 31'h7FFF_FFF0,   exp_ovf: 0, exp_div: 1};
        vecs[7]  = '{m: 31'd4,           n: 27'd7,   exp_m: 31'd64,          exp_ovf: 0, exp_div: 1};
        vecs[8]  = '{m: 31'd3,           n: 27'd8,   exp_m: 31'd48,          exp_ovf: 0, exp_div: 0};
        vecs[9]  = '{m: 31'd49,          n: 27'd10,  exp_m: 31'd49,          exp_ovf: 0, exp_div: 0};
        vecs[10] = '{m: 31'd50,          n: 27'd11,  exp_m: 31'd50,          exp_ovf: 0, exp_div: 1};

        bus.start = 1'b0;
        bus.cont = 1'b0;
        bus.result_ack = 1'b0;
        bus.m_cnt = '0;
        bus.n_cnt = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cnt_clr", bus.cnt_clr, 0);
        check("rst_gate_req", bus.gate_req, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.result_valid, 0);
        check("rst_results", {bus.div_sel, bus.m_out, bus.n_out, bus.no_signal, bus.overflow}, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            meas($sformatf("vec%0d", i), vecs[i].m, vecs[i].n, gl);
            check($sformatf("vec%0d_gate_len", i), gl, GATE);
            check($sformatf("vec%0d_busy", i), bus.busy, 1);
            check_res($sformatf("vec%0d", i), vecs[i].exp_m, vecs[i].n, 1'b0, vecs[i].exp_ovf,
                      vecs[i].exp_div);
            model_div = vecs[i].exp_div;
            do_ack($sformatf("vec%0d", i));
        end

        // Dead input: only the timeout can end the measurement.
        alive = 1'b0;
        meas("dead", 31'd123, 27'd45, gl);
        check("dead_open_cycles", gl, TMO);
        check_res("dead", 31'd0, 27'd0, 1'b1, 1'b0, 1'b0);
        model_div = 1'b0;
        alive = 1'b1;
        do_ack("dead");

        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 3))
                0:       m = 31'($urandom_range(0, 3));
                1:       m = 31'($urandom_range(4, 49));
                2:       m = 31'($urandom_range(50, 100000));
                default: m = 31'($urandom);
            endcase
            busy_dly = $urandom_range(1, 60);
            model_meas($sformatf("rnd%0d", i), m, 27'($urandom));
        end
        busy_dly = 5;

        // busy_s arriving after the gate timer expired keeps the gate open until seen.
        busy_dly = 120;
        ref_result(31'd7, model_div, mo, ovf, nrng);
        meas("late", 31'd7, 27'd70, gl);
        check("late_gate_len", (gl >= 118 && gl <= 126), 1);
        check_res("late", mo, 27'd70, 1'b0, ovf, nrng);
        model_div = nrng;
        do_ack("late");
        busy_dly = 5;

        // Continuous mode: re-arm on ack; a start during OPEN is ignored.
        bus.cont = 1'b1;
        bus.m_cnt = 31'd30;
        bus.n_cnt = 27'd300;
        ref_result(31'd30, model_div, mo, ovf, nrng);
        wait_result(2000, gl, cl, got);
        check("cont0_valid", got, 1);
        check("cont0_clr", cl, 1);
        check("cont0_gate_len", gl, GATE);
        check_res("cont0", mo, 27'd300, 1'b0, ovf, nrng);
        model_div = nrng;
        repeat (3) @(negedge clk);
        bus.result_ack = 1'b1;
        @(negedge clk);
        bus.result_ack = 1'b0;
        check("cont_rearm_clr", bus.cnt_clr, 1);
        check("cont_rearm_valid", bus.result_valid, 0);
        ref_result(31'd30, model_div, mo, ovf, nrng);
        fork
            begin
                repeat (20) @(negedge clk);
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
            end
        join_none
        wait_result(2000, gl, cl, got);
        check("cont1_valid", got, 1);
        check("cont1_start_ignored_clr", cl, 0);
        check("cont1_gate_len", gl, GATE);
        check_res("cont1", mo, 27'd300, 1'b0, ovf, nrng);
        model_div = nrng;

        // Ack together with start re-arms with no idle cycle.
        bus.cont = 1'b0;
        @(negedge clk);
        bus.result_ack = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.result_ack = 1'b0;
        bus.start = 1'b0;
        check("ackstart_clr", bus.cnt_clr, 1);
        check("ackstart_busy", bus.busy, 1);
        wait_result(2000, gl, cl, got);
        check("ackstart_valid", got, 1);
        check("ackstart_gate_len", gl, GATE);
        do_ack("ackstart");
        check("idle_busy", bus.busy, 0);
        model_div = nrng;

        // Mid-measurement reset, taken while in the /16 range.
        model_meas("prerst", 31'd60, 27'd12);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus.gate_req) got = 1'b1;
        end
        check("rstmid_gate_seen", got, 1);
        repeat (20) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rstmid_gate_req", bus.gate_req, 0);
        check("rstmid_busy", bus.busy, 0);
        check("rstmid_div_sel", bus.div_sel, 0);
        model_div = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.result_valid) vcnt++;
        end
        check("rstmid_no_valid", vcnt, 0);
        model_meas("postrst", 31'd25, 27'd250);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/f_measure_seq.md
# f_measure_seq

Measurement sequencer for the frequency-meter datapath. It runs each gated measurement in order: clears the counters, opens and closes the gate request, waits for the signal-synchronised gate to settle, and latches the signal-edge count M and the 50 MHz reference count N. It also auto-ranges between the direct and the ÷16-prescaled signal path, flags dead inputs by timeout, and presents scaled results to the display/divider stage through a valid/ack handshake.

## Interface
Parameters:
- GATE_CYCLES, 50_000_000: gate-request length in clk cycles (1 s at 50 MHz).
- TIMEOUT_CYCLES, 100_000_000: maximum wait for each gate edge from the datapath.
- M_HIGH, 10_000_000: M count (in direct range) at or above which the block switches to ÷16.
- M_LOW, 500_000: raw M count (in ÷16 range) below which the block switches back to direct.

Ports:
- clk  in  1  50 MHz system clock.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request for a single measurement.
- cont  in  1  continuous mode: re-arm automatically after each ack.
- cnt_busy  in  1  gate as synchronised to the signal by the datapath; asynchronous to clk.
- m_cnt  in  31  datapath signal-edge count.
- n_cnt  in  27  datapath reference-clock count.
- cnt_clr  out  1  one-cycle clear to the datapath counters.
- gate_req  out  1  requested gate.
- div_sel  out  1  0 = direct path, 1 = ÷16 path.
- busy  out  1  high in every state except IDLE.
- result_valid  out  1  result available; held until acked.
- result_ack  in  1  consumer acknowledge.
- m_out  out  31  scaled M.
- n_out  out  27  N.
- no_signal  out  1  the measurement timed out.
- overflow  out  1  the scaled M saturated.

## Operation
- Synchronizer: cnt_busy passes through 2 flops to produce busy_s. All decisions use busy_s.
- FSM states: IDLE, CLEAR, OPEN, CLOSE, LATCH, DONE.
- IDLE:
  - On start=1, or cont=1, go to CLEAR.
- CLEAR:
  - cnt_clr=1 for exactly one cycle, then go to OPEN.
  - The gate timer and timeout timer reset to 0.
- OPEN:
  - gate_req=1.
  - The gate timer increments every cycle.
  - The timeout timer increments while busy_s=0 and stops once busy_s has been seen high.
  - When the gate timer reaches GATE_CYCLES−1 and busy_s has been seen, go to CLOSE.
  - When the timeout timer reaches TIMEOUT_CYCLES−1 without busy_s, set the timeout flag and go to LATCH.
- CLOSE:
  - gate_req=0.
  - The timeout timer restarts from 0.
  - When busy_s=0, go to LATCH.
  - On timeout, set the timeout flag and go to LATCH.
- LATCH (one cycle):
  - If timeout: m_out=0, n_out=0, no_signal=1, overflow=0, and div_sel is forced to 0.
  - Otherwise, with div_sel=0: m_out=m_cnt.
  - Otherwise, with div_sel=1: m_out=m_cnt<<4. If m_cnt[30:27]≠0, m_out=31'h7FFF_FFFF and overflow=1.
  - On a non-timeout result, n_out=n_cnt and no_signal=0.
  - Range update for the next measurement uses the raw m_cnt:
    - div_sel 0→1 if m_cnt ≥ M_HIGH.
    - div_sel 1→0 if m_cnt < M_LOW.
  - The current result keeps the scaling of the range it was taken in.
- DONE:
  - result_valid=1.
  - On result_ack=1, go to CLEAR if cont=1 or start=1 in the same cycle; otherwise go to IDLE.
- start in any state other than IDLE and DONE is ignored (not queued).
- m_out, n_out, no_signal and overflow hold their values until the next LATCH.
- A change in div_sel takes effect at the next CLEAR. The datapath must not see div_sel change while gate_req=1.

## Timing
- Reset, sampled at a rising clk edge with rst=0:
  - State returns to IDLE.
  - All outputs go to 0, including div_sel.
  - Both timers and both synchronizer flops clear.
- Reset mid-measurement: gate_req drops in the same edge, and no result_valid is issued.
- Sequence latencies:
  - start (IDLE) → cnt_clr high on the next cycle.
  - gate_req rises one cycle after cnt_clr.
  - gate_req is high for exactly GATE_CYCLES cycles when busy_s rises before the gate timer expires. If busy_s rises later, it stays high until busy_s is seen.
  - cnt_busy edge → busy_s: 2–3 cycles.
  - busy_s falls → LATCH on the next cycle; result_valid one cycle after LATCH.
  - result_valid falls in the cycle after the ack edge.
- Simultaneous events:
  - Timeout and gate expiry in the same OPEN cycle: timeout wins.
  - Ack and start in DONE: immediate re-arm, with no IDLE cycle.
- Timer widths: $clog2 of the larger of GATE_CYCLES and TIMEOUT_CYCLES. Compare with ==, with no wrap-around.

## Test plan
For all scenarios: GATE_CYCLES=100, TIMEOUT_CYCLES=300, M_HIGH=50, M_LOW=4.
- Basic measurement: start pulse; model toggles cnt_busy 5 cycles after gate_req, with m_cnt=20 and n_cnt=100. Required: cnt_clr one cycle; gate_req 100 cycles; result_valid with m_out=20, n_out=100, div_sel=0, no_signal=0.
- Upward range switch: m_cnt=60 in direct range. Required: m_out=60 and div_sel→1. On the next measurement, m_cnt=10 gives m_out=160.
- Downward switch and saturation:
  - With div_sel=1, m_cnt=3 → m_out=48 and div_sel→0.
  - With div_sel=1, m_cnt=31'h0800_0000 → m_out=31'h7FFF_FFFF and overflow=1.
- Dead input: cnt_busy held at 0. Required: after 300 OPEN cycles, result_valid=1, no_signal=1, m_out=0, div_sel=0.
- Continuous mode and simultaneous start+ack: cont=1, ack asserted 3 cycles after valid. Required: cnt_clr on the cycle after the ack. A start pulse during OPEN has no effect.
- Reset mid-measurement: rst=0 for one edge during OPEN. Required: gate_req=0 and busy=0 after that edge, no result_valid, and a subsequent start is serviced normally.
